// File: rtl/fifo_wr_port_arb_pkg.sv
// rtl/fifo_wr_port_arb_pkg.sv - shared helpers for the FIFO RAM write-port arbiter
// Modular index arithmetic used by the rotating-priority scan and pointer update.
package fifo_wr_port_arb_pkg;

    function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                             input int unsigned n);
        return (a + b) % n;
    endfunction

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 == n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_port_arb_rr_prio_pick.sv
// rtl/fifo_wr_port_arb_rr_prio_pick.sv - rotating-priority first-one finder with mask
// Scans req starting at start (mod N) and returns the first set, unmasked bit.
module rr_prio_pick
    import fifo_wr_port_arb_pkg::*;
#(
    parameter int N = 4,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [N-1:0] mask,
    input  logic [W-1:0] start,
    output logic         found,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot
);

    int unsigned j;

    always_comb begin
        found  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int k = 0; k < N; k++) begin
            j = wrap_add(32'(start), k, N);
            if (!found && req[j] && !mask[j]) begin
                found     = 1'b1;
                idx       = W'(j);
                onehot[j] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_port_arb.sv
// rtl/fifo_wr_port_arb.sv - shares FIFO RAM write ports among writeback requesters
// 1-deep pending slot per requester, drained by a chain of rotating-priority pickers.
module fifo_wr_port_arb
    import fifo_wr_port_arb_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int N_WRITE_PORTS = 2,
    parameter int PTR_WIDTH     = 3,
    parameter int ENTRY_WIDTH   = 32,
    localparam int RR_WIDTH     = $clog2(N_REQ)
) (
    input  logic                                         clk,
    input  logic                                         rst_aH,
    input  logic                                         flush,
    input  logic                                         wr_block,
    input  logic [N_REQ-1:0]                             req_valid,
    output logic [N_REQ-1:0]                             req_ready,
    input  logic [N_REQ-1:0][PTR_WIDTH-1:0]              req_addr,
    input  logic [N_REQ-1:0][ENTRY_WIDTH-1:0]            req_data,
    output logic [N_WRITE_PORTS-1:0]                     wr_en,
    output logic [N_WRITE_PORTS-1:0][PTR_WIDTH-1:0]      wr_addr,
    output logic [N_WRITE_PORTS-1:0][ENTRY_WIDTH-1:0]    wr_data,
    output logic [N_REQ-1:0]                             grant,
    output logic [RR_WIDTH:0]                            pend_cnt
);

    logic [N_REQ-1:0]       pend_valid_q, pend_valid_d;
    logic [PTR_WIDTH-1:0]   pend_addr_q [N_REQ];
    logic [PTR_WIDTH-1:0]   pend_addr_d [N_REQ];
    logic [ENTRY_WIDTH-1:0] pend_data_q [N_REQ];
    logic [ENTRY_WIDTH-1:0] pend_data_d [N_REQ];
    logic [RR_WIDTH-1:0]    rr_ptr_q, rr_ptr_d;

    logic                   arb_en;
    logic [N_REQ-1:0]       eligible;

    logic [N_WRITE_PORTS-1:0]               port_found;
    logic [N_WRITE_PORTS-1:0][RR_WIDTH-1:0] port_idx;
    logic [N_WRITE_PORTS-1:0][N_REQ-1:0]    port_onehot;

    assign arb_en    = ~wr_block & ~flush & ~rst_aH;
    assign eligible  = pend_valid_q & {N_REQ{arb_en}};
    assign req_ready = ~pend_valid_q & {N_REQ{~flush & ~rst_aH}};

    // Each stage excludes slots already granted and slots aiming at an already-granted entry,
    // so the later slot in scan order waits rather than colliding.
    for (genvar p = 0; p < N_WRITE_PORTS; p++) begin : g_port
        logic [N_REQ-1:0]    mask;
        logic                found;
        logic [RR_WIDTH-1:0] idx;
        logic [N_REQ-1:0]    onehot;

        if (p == 0) begin : g_first
            assign mask = '0;
        end else begin : g_next
            logic [N_REQ-1:0] addr_hit;
            always_comb begin
                addr_hit = '0;
                for (int i = 0; i < N_REQ; i++) begin
                    addr_hit[i] = g_port[p-1].found &&
                                  (pend_addr_q[i] == pend_addr_q[g_port[p-1].idx]);
                end
            end
            assign mask = g_port[p-1].mask | g_port[p-1].onehot | addr_hit;
        end

        rr_prio_pick #(.N(N_REQ)) u_pick (
            .req    (eligible),
            .mask   (mask),
            .start  (rr_ptr_q),
            .found  (found),
            .idx    (idx),
            .onehot (onehot)
        );

        assign port_found[p]  = found;
        assign port_idx[p]    = idx;
        assign port_onehot[p] = onehot;
        assign wr_en[p]       = found;
        assign wr_addr[p]     = found ? pend_addr_q[idx] : '0;
        assign wr_data[p]     = found ? pend_data_q[idx] : '0;
    end

    always_comb begin
        grant = '0;
        for (int p = 0; p < N_WRITE_PORTS; p++) begin
            grant = grant | port_onehot[p];
        end
    end

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < N_REQ; i++) begin
            pend_cnt = pend_cnt + {{RR_WIDTH{1'b0}}, pend_valid_q[i]};
        end
    end

    always_comb begin
        pend_valid_d = pend_valid_q & ~grant;
        pend_addr_d  = pend_addr_q;
        pend_data_d  = pend_data_q;
        rr_ptr_d     = rr_ptr_q;
        for (int i = 0; i < N_REQ; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                pend_valid_d[i] = 1'b1;
                pend_addr_d[i]  = req_addr[i];
                pend_data_d[i]  = req_data[i];
            end
        end
        // Grants fill ports in scan order, so the highest active port holds the last slot.
        for (int p = 0; p < N_WRITE_PORTS; p++) begin
            if (port_found[p]) begin
                rr_ptr_d = RR_WIDTH'(wrap_inc(32'(port_idx[p]), N_REQ));
            end
        end
        if (flush) begin
            pend_valid_d = '0;
            rr_ptr_d     = '0;
        end
    end

    always_ff @(posedge clk or posedge rst_aH) begin
        if (rst_aH) begin
            pend_valid_q <= '0;
            rr_ptr_q     <= '0;
            for (int i = 0; i < N_REQ; i++) begin
                pend_addr_q[i] <= '0;
                pend_data_q[i] <= '0;
            end
        end else begin
            pend_valid_q <= pend_valid_d;
            rr_ptr_q     <= rr_ptr_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

endmodule
